// File: rtl/spi_host_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : spi_host_pkg                                         |
// | Description : Shared opcodes, FSM state encoding and status bit    |
// |               positions for the host SPI receive front end.        |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package spi_host_pkg;

   // Image FIFO word width shared with the programmer side
   localparam int FIFO_W = 16;

   // Host opcodes (first byte of every frame)
   localparam logic [7:0] OP_WR_CMD    = 8'h01;
   localparam logic [7:0] OP_WR_IMAGE  = 8'h02;
   localparam logic [7:0] OP_RD_STATUS = 8'h03;
   localparam logic [7:0] OP_CLR_ERR   = 8'h04;

   // Bit positions inside the status byte returned to the host
   localparam int STAT_PROGRAM_DONE  = 0;
   localparam int STAT_VERIFY_DONE   = 1;
   localparam int STAT_PROGRAM_ERROR = 2;
   localparam int STAT_SPI_VIOLATION = 3;
   localparam int STAT_SPI_PROCESS   = 4;

   // Frame decoder states
   typedef enum logic [2:0] {
      ST_WAIT_IDLE = 3'd0,
      ST_IDLE      = 3'd1,
      ST_OPCODE    = 3'd2,
      ST_WR_CMD    = 3'd3,
      ST_WR_IMAGE  = 3'd4,
      ST_RD_STATUS = 3'd5,
      ST_DISCARD   = 3'd6
   } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : spi_pin_sync                                         |
// | Description : Synchronises the host SPI pins into sys_clk and      |
// |               produces registered single-cycle edge pulses.        |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module spi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic nrst,
   input  logic sck_in,
   input  logic nss_in,
   input  logic mosi_in,
   output logic sck_rise,
   output logic sck_fall,
   output logic nss_rise,
   output logic nss_fall,
   output logic nss_level,
   output logic mosi
);

   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_nss_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sck_prev;

   // Synchroniser chains; NSS clears to 0 so a frame in progress at reset
   // release is seen as "still selected" and never as a fresh start.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_sck_sync  <= '0;
         r_nss_sync  <= '0;
         r_mosi_sync <= '0;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck_in};
         r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0], nss_in};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
      end
   end

   // Registered edge pulses; MOSI and NSS level are delayed alongside so
   // every output belongs to the same sample.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_sck_prev <= 1'b0;
         sck_rise   <= 1'b0;
         sck_fall   <= 1'b0;
         nss_level  <= 1'b0;
         nss_rise   <= 1'b0;
         nss_fall   <= 1'b0;
         mosi       <= 1'b0;
      end else begin
         r_sck_prev <= r_sck_sync[SYNC_STAGES-1];
         sck_rise   <=  r_sck_sync[SYNC_STAGES-1] & ~r_sck_prev;
         sck_fall   <= ~r_sck_sync[SYNC_STAGES-1] &  r_sck_prev;
         nss_level  <= r_nss_sync[SYNC_STAGES-1];
         nss_rise   <=  r_nss_sync[SYNC_STAGES-1] & ~nss_level;
         nss_fall   <= ~r_nss_sync[SYNC_STAGES-1] &  nss_level;
         mosi       <= r_mosi_sync[SYNC_STAGES-1];
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_host_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : spi_host_rx                                          |
// | Description : Oversampled SPI slave: decodes host frames, fills    |
// |               the image FIFO, loads the command register and       |
// |               returns status snapshots on MISO.                    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module spi_host_rx
   import spi_host_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_W      = FIFO_W
) (
   input  logic              sys_clk,
   input  logic              sys_nrst,
   input  logic              spi_sck,
   input  logic              spi_nss,
   input  logic              spi_mosi,
   output logic              spi_miso,
   input  logic              fifo_full,
   output logic              fifo_wr_en,
   output logic [DATA_W-1:0] fifo_wr_data,
   output logic [15:0]       command,
   input  logic [7:0]        status_in,
   output logic              overflow_err,
   output logic              frame_err
);

   logic       w_sck_rise, w_sck_fall, w_nss_rise, w_nss_fall, w_nss_hi, w_mosi;
   state_t     r_state, w_next_state;
   logic [2:0] r_bit_cnt;
   logic [6:0] r_rx_shreg;
   logic       r_byte_done;
   logic [7:0] r_rx_byte;
   logic [7:0] r_tx_shreg;
   logic [7:0] r_cmd_lo;
   logic       r_cmd_have_lo;
   logic       r_cmd_done;
   logic [7:0] r_img_lo;
   logic       r_img_have_lo;
   logic       w_active;
   logic       w_shift_en;
   logic       w_status_load;

   spi_pin_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_pin_sync (
      .clk       (sys_clk),
      .nrst      (sys_nrst),
      .sck_in    (spi_sck),
      .nss_in    (spi_nss),
      .mosi_in   (spi_mosi),
      .sck_rise  (w_sck_rise),
      .sck_fall  (w_sck_fall),
      .nss_rise  (w_nss_rise),
      .nss_fall  (w_nss_fall),
      .nss_level (w_nss_hi),
      .mosi      (w_mosi)
   );

   assign w_active      = (r_state != ST_WAIT_IDLE) && (r_state != ST_IDLE);
   assign w_shift_en    = w_active && (r_state != ST_DISCARD) && !w_nss_hi;
   assign w_status_load = r_byte_done && !w_nss_hi &&
                          (((r_state == ST_OPCODE) && (r_rx_byte == OP_RD_STATUS)) ||
                           (r_state == ST_RD_STATUS));

   // State register
   always_ff @(posedge sys_clk) begin
      if (!sys_nrst) r_state <= ST_WAIT_IDLE;
      else           r_state <= w_next_state;
   end

   // Next-state decode: NSS high always ends a frame; opcode dispatch on byte completion
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_WAIT_IDLE: if (w_nss_hi)   w_next_state = ST_IDLE;
         ST_IDLE:      if (w_nss_fall) w_next_state = ST_OPCODE;
         default: begin
            if (w_nss_hi) begin
               w_next_state = ST_IDLE;
            end else if ((r_state == ST_OPCODE) && r_byte_done) begin
               case (r_rx_byte)
                  OP_WR_CMD:    w_next_state = ST_WR_CMD;
                  OP_WR_IMAGE:  w_next_state = ST_WR_IMAGE;
                  OP_RD_STATUS: w_next_state = ST_RD_STATUS;
                  default:      w_next_state = ST_DISCARD;
               endcase
            end
         end
      endcase
   end

   // Receive shifter: MSB first, byte_done pulses one cycle after the 8th bit
   always_ff @(posedge sys_clk) begin
      if (!sys_nrst) begin
         r_bit_cnt   <= 3'd0;
         r_rx_shreg  <= 7'd0;
         r_byte_done <= 1'b0;
         r_rx_byte   <= 8'd0;
      end else begin
         r_byte_done <= 1'b0;
         if (!w_shift_en) begin
            r_bit_cnt <= 3'd0;
         end else if (w_sck_rise) begin
            r_rx_shreg <= {r_rx_shreg[5:0], w_mosi};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               r_byte_done <= 1'b1;
               r_rx_byte   <= {r_rx_shreg, w_mosi};
            end
         end
      end
   end

   // Frame decoding: command load, image packing, sticky error flags
   always_ff @(posedge sys_clk) begin
      if (!sys_nrst) begin
         fifo_wr_en    <= 1'b0;
         fifo_wr_data  <= '0;
         command       <= 16'd0;
         overflow_err  <= 1'b0;
         frame_err     <= 1'b0;
         r_cmd_lo      <= 8'd0;
         r_cmd_have_lo <= 1'b0;
         r_cmd_done    <= 1'b0;
         r_img_lo      <= 8'd0;
         r_img_have_lo <= 1'b0;
      end else begin
         fifo_wr_en <= 1'b0;
         if (r_state == ST_IDLE) begin
            r_cmd_have_lo <= 1'b0;
            r_cmd_done    <= 1'b0;
            r_img_have_lo <= 1'b0;
         end else if (w_nss_rise && w_active) begin
            if (r_bit_cnt != 3'd0)                         frame_err <= 1'b1;
            if ((r_state == ST_WR_IMAGE) && r_img_have_lo) frame_err <= 1'b1;
            if ((r_state == ST_WR_CMD) && !r_cmd_done)     frame_err <= 1'b1;
         end else if (r_byte_done && !w_nss_hi) begin
            case (r_state)
               ST_OPCODE: begin
                  if (r_rx_byte == OP_CLR_ERR) begin
                     overflow_err <= 1'b0;
                     frame_err    <= 1'b0;
                  end else if ((r_rx_byte != OP_WR_CMD) && (r_rx_byte != OP_WR_IMAGE) &&
                               (r_rx_byte != OP_RD_STATUS)) begin
                     frame_err <= 1'b1;
                  end
               end
               ST_WR_CMD: begin
                  if (!r_cmd_have_lo) begin
                     r_cmd_lo      <= r_rx_byte;
                     r_cmd_have_lo <= 1'b1;
                  end else if (!r_cmd_done) begin
                     command    <= {r_rx_byte, r_cmd_lo};
                     r_cmd_done <= 1'b1;
                  end
               end
               ST_WR_IMAGE: begin
                  if (!r_img_have_lo) begin
                     r_img_lo      <= r_rx_byte;
                     r_img_have_lo <= 1'b1;
                  end else begin
                     r_img_have_lo <= 1'b0;
                     if (fifo_full) begin
                        overflow_err <= 1'b1;
                     end else begin
                        fifo_wr_en   <= 1'b1;
                        fifo_wr_data <= {r_rx_byte, r_img_lo};
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Status return: snapshot on each byte boundary, shifted out on SCK falls
   always_ff @(posedge sys_clk) begin
      if (!sys_nrst) begin
         r_tx_shreg <= 8'd0;
         spi_miso   <= 1'b0;
      end else begin
         if (w_status_load) begin
            r_tx_shreg <= status_in;
         end else if ((r_state == ST_RD_STATUS) && !w_nss_hi && w_sck_fall) begin
            spi_miso   <= r_tx_shreg[7];
            r_tx_shreg <= {r_tx_shreg[6:0], 1'b0};
         end
         if ((r_state != ST_RD_STATUS) || w_nss_hi) spi_miso <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_host_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_spi_host_rx                                       |
// | Description : Self-checking bench for spi_host_rx: directed frame  |
// |               table, latency and reset corner cases, random frames |
// |               against a frame-level reference model.               |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_spi_host_rx;

   localparam int SYNC = 2;
   localparam int H    = 8;   // sys_clk cycles per SCK half period

   logic        sys_clk   = 1'b0;
   logic        sys_nrst  = 1'b0;
   logic        spi_sck   = 1'b0;
   logic        spi_nss   = 1'b1;
   logic        spi_mosi  = 1'b0;
   logic        fifo_full = 1'b0;
   logic [7:0]  status_in = 8'd0;
   logic        spi_miso;
   logic        fifo_wr_en;
   logic [15:0] fifo_wr_data;
   logic [15:0] command;
   logic        overflow_err;
   logic        frame_err;

   int checks = 0;
   int errors = 0;

   logic [15:0] wq[$];     // writes observed on the FIFO port
   logic [15:0] m_wq[$];   // writes predicted by the model
   logic [15:0] m_cmd;
   bit          m_ovf, m_ferr;

   always #5 sys_clk = ~sys_clk;

   spi_host_rx #(.SYNC_STAGES(SYNC), .DATA_W(16)) dut (
      .sys_clk      (sys_clk),
      .sys_nrst     (sys_nrst),
      .spi_sck      (spi_sck),
      .spi_nss      (spi_nss),
      .spi_mosi     (spi_mosi),
      .spi_miso     (spi_miso),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .command      (command),
      .status_in    (status_in),
      .overflow_err (overflow_err),
      .frame_err    (frame_err)
   );

   // Collect every write strobe
   always @(negedge sys_clk) begin
      if (fifo_wr_en) wq.push_back(fifo_wr_data);
   end

   // Watchdog
   initial begin
      #3ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b, output logic r);
      spi_mosi = b;
      repeat (H) @(negedge sys_clk);
      r = spi_miso;
      spi_sck = 1'b1;
      repeat (H) @(negedge sys_clk);
      spi_sck = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         send_bit(tx[i], r);
         rx[i] = r;
      end
   endtask

   // One complete frame: n whole bytes, xb trailing partial bits, status_in
   // set to st[i] while frame byte i is being shifted.
   task automatic run_frame(input int n, input logic [5:0][7:0] b, input logic [5:0][7:0] st,
                            input int xb, input bit full, output logic [5:0][7:0] rd);
      logic [7:0] r8;
      logic       r1;
      rd = '0;
      wq.delete();
      fifo_full = full;
      spi_nss = 1'b0;
      repeat (H) @(negedge sys_clk);
      for (int i = 0; i < n; i++) begin
         status_in = st[i];
         spi_byte(b[i], r8);
         rd[i] = r8;
      end
      for (int i = 0; i < xb; i++) send_bit(1'($urandom_range(0, 1)), r1);
      repeat (H) @(negedge sys_clk);
      spi_nss = 1'b1;
      repeat (3 * H) @(negedge sys_clk);
      fifo_full = 1'b0;
   endtask

   // Frame-level reference: effect of a whole frame on command, flags, FIFO
   function automatic void model_frame(input int n, input logic [5:0][7:0] b, input int xb,
                                       input bit full);
      int         np;
      logic [7:0] op;
      m_wq.delete();
      if (n == 0) begin
         if (xb > 0) m_ferr = 1'b1;
         return;
      end
      op = b[0];
      np = n - 1;
      case (op)
         8'h01: if (np >= 2) m_cmd = {b[2], b[1]}; else m_ferr = 1'b1;
         8'h02: begin
            for (int k = 0; k + 1 < np; k += 2) begin
               if (full) m_ovf = 1'b1;
               else      m_wq.push_back({b[2 + k], b[1 + k]});
            end
            if (np % 2 != 0) m_ferr = 1'b1;
         end
         8'h03: ;
         8'h04: begin m_ovf = 1'b0; m_ferr = 1'b0; end
         default: m_ferr = 1'b1;
      endcase
      if (xb > 0 && (op == 8'h01 || op == 8'h02 || op == 8'h03)) m_ferr = 1'b1;
   endfunction

   typedef struct {
      int               n;
      logic [5:0][7:0]  b;
      logic [5:0][7:0]  st;
      int               xb;
      bit               full;
      logic [15:0]      cmd;
      int               nw;
      logic [1:0][15:0] w;
      bit               ovf;
      bit               ferr;
      int               nr;
      logic [1:0][7:0]  r;
   } vec_t;

   function automatic vec_t mk(int n, logic [47:0] b, logic [47:0] st, int xb, bit full,
                               logic [15:0] cmd, int nw, logic [31:0] w, bit ovf, bit ferr,
                               int nr, logic [15:0] r);
      vec_t v;
      v.n = n; v.b = b; v.st = st; v.xb = xb; v.full = full; v.cmd = cmd;
      v.nw = nw; v.w = w; v.ovf = ovf; v.ferr = ferr; v.nr = nr; v.r = r;
      return v;
   endfunction

   initial begin
      vec_t            tbl[12];
      logic [5:0][7:0] rd;
      logic [7:0]      r8, hi;
      logic            r1;
      logic [7:0]      exp_rd;

      tbl[0]  = mk(3, 48'h0000_0000_0601, 48'h0, 0, 0, 16'h0006, 0, 32'h0, 0, 0, 0, 16'h0);
      tbl[1]  = mk(5, 48'h00DD_CCBB_AA02, 48'h0, 0, 0, 16'h0006, 2, 32'hDDCC_BBAA, 0, 0, 0, 16'h0);
      tbl[2]  = mk(3, 48'h0000_0000_0003, 48'h0000_0000_0205, 0, 0, 16'h0006, 0, 32'h0, 0, 0, 2, 16'h0205);
      tbl[3]  = mk(3, 48'h0000_0022_1102, 48'h0, 0, 1, 16'h0006, 0, 32'h0, 1, 0, 0, 16'h0);
      tbl[4]  = mk(1, 48'h04, 48'h0, 0, 0, 16'h0006, 0, 32'h0, 0, 0, 0, 16'h0);
      tbl[5]  = mk(2, 48'h1102, 48'h0, 0, 0, 16'h0006, 0, 32'h0, 0, 1, 0, 16'h0);
      tbl[6]  = mk(1, 48'h04, 48'h0, 0, 0, 16'h0006, 0, 32'h0, 0, 0, 0, 16'h0);
      tbl[7]  = mk(1, 48'h7F, 48'h0, 0, 0, 16'h0006, 0, 32'h0, 0, 1, 0, 16'h0);
      tbl[8]  = mk(1, 48'h04, 48'h0, 0, 0, 16'h0006, 0, 32'h0, 0, 0, 0, 16'h0);
      tbl[9]  = mk(0, 48'h0, 48'h0, 5, 0, 16'h0006, 0, 32'h0, 0, 1, 0, 16'h0);
      tbl[10] = mk(1, 48'h04, 48'h0, 0, 0, 16'h0006, 0, 32'h0, 0, 0, 0, 16'h0);
      tbl[11] = mk(2, 48'h5501, 48'h0, 0, 0, 16'h0006, 0, 32'h0, 0, 1, 0, 16'h0);

      // Reset values
      repeat (5) @(negedge sys_clk);
      chk("rst_miso", spi_miso, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_wr_data", fifo_wr_data, 0);
      chk("rst_command", command, 0);
      chk("rst_ovf", overflow_err, 0);
      chk("rst_ferr", frame_err, 0);
      sys_nrst = 1'b1;
      repeat (10) @(negedge sys_clk);

      // Directed frame table
      for (int i = 0; i < 12; i++) begin
         run_frame(tbl[i].n, tbl[i].b, tbl[i].st, tbl[i].xb, tbl[i].full, rd);
         chk($sformatf("row%0d_cmd", i), command, tbl[i].cmd);
         chk($sformatf("row%0d_ovf", i), overflow_err, tbl[i].ovf);
         chk($sformatf("row%0d_ferr", i), frame_err, tbl[i].ferr);
         chk($sformatf("row%0d_nwr", i), wq.size(), tbl[i].nw);
         for (int k = 0; k < tbl[i].nw && k < wq.size(); k++)
            chk($sformatf("row%0d_wr%0d", i, k), wq[k], tbl[i].w[k]);
         for (int k = 0; k < tbl[i].n; k++) begin
            exp_rd = (k >= 1 && k - 1 < tbl[i].nr) ? tbl[i].r[k - 1] : 8'h00;
            chk($sformatf("row%0d_rd%0d", i, k), rd[k], exp_rd);
         end
      end

      // Latency: strobe appears exactly SYNC+2 edges after the final SCK rise is sampled
      wq.delete();
      spi_nss = 1'b0;
      repeat (H) @(negedge sys_clk);
      spi_byte(8'h02, r8);
      spi_byte(8'h78, r8);
      hi = 8'h56;
      for (int i = 7; i >= 1; i--) send_bit(hi[i], r1);
      spi_mosi = hi[0];
      repeat (H) @(negedge sys_clk);
      spi_sck = 1'b1;
      repeat (SYNC + 2) @(negedge sys_clk);
      chk("lat_early", fifo_wr_en, 0);
      @(negedge sys_clk);
      chk("lat_strobe", fifo_wr_en, 1);
      chk("lat_data", fifo_wr_data, 16'h5678);
      @(negedge sys_clk);
      chk("lat_one_cycle", fifo_wr_en, 0);
      repeat (H) @(negedge sys_clk);
      spi_sck = 1'b0;
      repeat (H) @(negedge sys_clk);
      spi_nss = 1'b1;
      repeat (3 * H) @(negedge sys_clk);
      chk("lat_nwr", wq.size(), 1);

      // Reset in the middle of an image frame, clocking carries on
      wq.delete();
      spi_nss = 1'b0;
      repeat (H) @(negedge sys_clk);
      spi_byte(8'h02, r8);
      spi_byte(8'hAA, r8);
      for (int i = 0; i < 3; i++) send_bit(1'b1, r1);
      sys_nrst = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk("midrst_command", command, 0);
      chk("midrst_ferr", frame_err, 0);
      sys_nrst = 1'b1;
      for (int i = 0; i < 5; i++) send_bit(1'b0, r1);
      spi_byte(8'hBB, r8);
      spi_byte(8'hCC, r8);
      repeat (H) @(negedge sys_clk);
      chk("midrst_nowr_before_nss", wq.size(), 0);
      spi_nss = 1'b1;
      repeat (3 * H) @(negedge sys_clk);
      chk("midrst_nwr", wq.size(), 0);
      chk("midrst_ferr_after", frame_err, 0);
      run_frame(3, 48'h0000_0000_1234 << 8 | 48'h02, 48'h0, 0, 0, rd);
      chk("midrst_next_nwr", wq.size(), 1);
      if (wq.size() > 0) chk("midrst_next_data", wq[0], 16'h1234);

      // Randomised frames against the reference model
      m_cmd = 16'h0000; m_ovf = 1'b0; m_ferr = 1'b0;
      for (int f = 0; f < 30; f++) begin
         int              n, xb, sel;
         bit              full;
         logic [7:0]      op;
         logic [5:0][7:0] b, st;
         sel = $urandom_range(0, 4);
         op  = (sel == 4) ? 8'($urandom_range(0, 255)) : 8'(sel + 1);
         n   = 1 + $urandom_range(0, 5);
         for (int k = 0; k < 6; k++) begin
            b[k]  = 8'($urandom_range(0, 255));
            st[k] = 8'($urandom_range(0, 255));
         end
         b[0] = op;
         xb   = ((op == 8'h01 || op == 8'h02 || op == 8'h03) && $urandom_range(0, 3) == 0)
                ? $urandom_range(1, 7) : 0;
         full = ($urandom_range(0, 3) == 0);
         model_frame(n, b, xb, full);
         run_frame(n, b, st, xb, full, rd);
         chk($sformatf("rnd%0d_cmd", f), command, m_cmd);
         chk($sformatf("rnd%0d_ovf", f), overflow_err, m_ovf);
         chk($sformatf("rnd%0d_ferr", f), frame_err, m_ferr);
         chk($sformatf("rnd%0d_nwr", f), wq.size(), m_wq.size());
         for (int k = 0; k < m_wq.size() && k < wq.size(); k++)
            chk($sformatf("rnd%0d_wr%0d", f, k), wq[k], m_wq[k]);
         for (int k = 0; k < n; k++) begin
            exp_rd = (op == 8'h03 && k >= 1) ? st[k - 1] : 8'h00;
            chk($sformatf("rnd%0d_rd%0d", f, k), rd[k], exp_rd);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_host_rx.md
Name: spi_host_rx

Overview:
- SPI-slave front end that receives the image and control traffic from the external host and fills the image FIFO drained by the programmer.
- Drives the programmer's 16-bit command register and returns a status byte to the host.
- Sits between the host SPI pins and the image FIFO write port / programmer control inputs.
- Fully synchronous to sys_clk; the SPI pins are oversampled, and no SCK clock domain exists.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronisers on spi_sck, spi_nss and spi_mosi (min 2)
DATA_W, 16, FIFO word width (fixed at 16; the parameter exists for the shared package)

Ports:
sys_clk  in  1  system clock; must be at least 8x the SCK frequency
sys_nrst  in  1  reset, synchronous, active-low
spi_sck  in  1  host SPI clock, mode 0 (idle low, sample on rising edge)
spi_nss  in  1  host chip select, active-low
spi_mosi  in  1  host data in, MSB first
spi_miso  out  1  data out to host
fifo_full  in  1  image FIFO full
fifo_wr_en  out  1  one-cycle write strobe
fifo_wr_data  out  16  image word; first received byte goes in [7:0]
command  out  16  programmer command register
status_in  in  8  {3'b0, spi_process_err, spi_violation_err, program_error, verify_done, program_done}
overflow_err  out  1  sticky; an image word was dropped because fifo_full was high
frame_err  out  1  sticky; a frame was malformed

Behaviour:
- Reset values: spi_miso=0, fifo_wr_en=0, fifo_wr_data=0, command=0, overflow_err=0, frame_err=0; FSM in WAIT_IDLE.
- Synchronisers and edge detect:
  - spi_sck, spi_nss and spi_mosi each pass through SYNC_STAGES flops.
  - sck_rise and sck_fall are single-cycle pulses taken from the synchronised SCK.
  - spi_mosi is sampled on sck_rise.
- FSM states and transitions:
  - WAIT_IDLE -> IDLE when synchronised NSS is high. This also applies after reset mid-frame, so a partial frame is never decoded.
  - IDLE -> OPCODE on NSS low.
  - OPCODE: 8 bits are shifted in, then dispatched on the 8th sck_rise:
    - 0x01 -> WR_CMD
    - 0x02 -> WR_IMAGE
    - 0x03 -> RD_STATUS
    - 0x04 -> clears overflow_err and frame_err in that cycle, then goes to DISCARD
    - any other value -> sets frame_err, then goes to DISCARD
  - WR_CMD: the first payload byte is held as command[7:0]. On completion of the second byte, command is updated atomically as {byte2, byte1}. Any further bytes are ignored.
  - WR_IMAGE: bytes are paired low-then-high. On completion of the second byte of a pair:
    - fifo_full=0: fifo_wr_data={hi,lo} and fifo_wr_en=1 for exactly one cycle.
    - fifo_full=1: no write; overflow_err is set and the word is discarded.
  - RD_STATUS: status_in is captured into the MISO shift register on the 8th sck_rise of the opcode. It is recaptured on every later byte completion, so every byte read returns a fresh snapshot.
  - DISCARD: clocks are ignored until NSS goes high.
- Any state -> IDLE on NSS high. Checks at that point:
  - Bit counter nonzero: frame_err is set and the partial byte is discarded.
  - WR_IMAGE holding an unpaired low byte: frame_err is set and the byte is discarded.
  - WR_CMD with fewer than 2 payload bytes: command is unchanged and frame_err is set.
- MISO timing:
  - On each sck_fall, spi_miso <= shreg[7] and shreg shifts left.
  - Outside RD_STATUS, spi_miso is 0.
  - The falling edge after the 8th opcode rising edge presents the status MSB.
  - spi_miso returns to 0 on NSS high.
- Latency:
  - fifo_wr_en and the command update occur exactly SYNC_STAGES+2 sys_clk cycles after the first sys_clk edge that samples the final SCK rising edge high.
- Bit and byte counters are 3-bit and wrap 7->0 on each byte boundary. The byte-pair toggle resets at each frame start.
- Simultaneous events:
  - Opcode 0x04 clear in the same cycle as a new overflow: the clear wins. This cannot happen within one frame, but the rule is stated for formal checking.
  - fifo_wr_en never asserts while fifo_full=1.

Decomposition:
- spi_host_pkg holds the opcode constants (OP_WR_CMD=8'h01, OP_WR_IMAGE=8'h02, OP_RD_STATUS=8'h03, OP_CLR_ERR=8'h04), the FSM state enum and the status bit indices.
- One sub-module, spi_pin_sync, contains the SYNC_STAGES synchronisers plus the sck_rise/sck_fall/nss_fall/nss_rise pulse generation. The FSM, shift registers and packing stay in spi_host_rx.

Test Plan:
- Frame 0x01,0x06,0x00 -> command=16'h0006 after the last byte; no FIFO write; frame_err=0.
- Frame 0x02,0xAA,0xBB,0xCC,0xDD -> two fifo_wr_en pulses carrying 16'hBBAA then 16'hDDCC.
- Frame 0x03 plus 2 dummy bytes with status_in=8'h05, changed to 8'h02 between bytes -> host reads 0x05 then 0x02.
- fifo_full held high during frame 0x02,0x11,0x22 -> no fifo_wr_en; overflow_err=1; then frame 0x04 -> overflow_err=0, frame_err=0.
- Frame 0x02,0x11 then NSS high; opcode 0x7F; NSS high after 5 bits -> frame_err=1 in each case; no write; command unchanged.
- Reset asserted mid-frame in WR_IMAGE, released while NSS still low and clocking continues -> no writes until NSS rises; the next full frame 0x02,0x34,0x12 writes 16'h1234.
